// File: rtl/hwpe_job_ctrl_if.sv
// Control-port bundle between the upstream AXI-to-TCDM converter (master)
// and hwpe_job_ctrl (slave).
//   req_i/add_i/wen_i/be_i/data_i : request from the converter
//   gnt_o                         : combinational grant from the controller
//   r_valid_o/r_data_o            : registered response, one cycle after grant
interface hwpe_job_ctrl_if;
   logic        req_i;
   logic        gnt_o;
   logic [31:0] add_i;
   logic        wen_i;
   logic [3:0]  be_i;
   logic [31:0] data_i;
   logic        r_valid_o;
   logic [31:0] r_data_o;

   modport master (
      output req_i, add_i, wen_i, be_i, data_i,
      input  gnt_o, r_valid_o, r_data_o
   );

   modport slave (
      input  req_i, add_i, wen_i, be_i, data_i,
      output gnt_o, r_valid_o, r_data_o
   );
endinterface

// File: rtl/hwpe_job_ctrl.sv
// Job controller for a hardware processing engine: a small register file on
// the control port stages job arguments, TRIGGER pushes them with a job id
// into a job queue, the queue head is handed to the engine, and completion
// raises masked events towards the cores.
//
// Ports:
//   clk_i, rst_i     : clock, asynchronous active-high reset
//   ctrl             : control-port request/response (hwpe_job_ctrl_if.slave)
//   job_valid_o      : queue head offered to the engine
//   job_ready_i      : engine accepts the head
//   job_args_o       : head job arguments (NumArgs x 32 bit)
//   job_id_o         : head job id
//   job_done_i       : one-cycle completion pulse from the engine
//   evt_o            : one-cycle completion events per core (EVT_MASK)
//
// Configuration macro HWPE_JOB_CTRL_SHADOW_EN: when defined the queue holds
// two jobs besides the one in flight; when undefined the queue holds one job
// and the in-flight job counts as occupying it.
module hwpe_job_ctrl #(
   parameter int unsigned NrCores = 9,
   parameter int unsigned NumArgs = 8
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   hwpe_job_ctrl_if.slave          ctrl,
   output logic                    job_valid_o,
   input  logic                    job_ready_i,
   output logic [NumArgs*32-1:0]   job_args_o,
   output logic [7:0]              job_id_o,
   input  logic                    job_done_i,
   output logic [NrCores-1:0]      evt_o
);

   localparam int unsigned ArgW = NumArgs * 32;
`ifdef HWPE_JOB_CTRL_SHADOW_EN
   localparam int unsigned QDepth = 2;
`else
   localparam int unsigned QDepth = 1;
`endif

   localparam logic [5:0] OffTrigger = 6'd0;
   localparam logic [5:0] OffStatus  = 6'd1;
   localparam logic [5:0] OffEvtMask = 6'd2;
   localparam logic [5:0] OffClear   = 6'd3;
   localparam logic [5:0] OffArgBase = 6'd16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PENDING = 2'd1,
      RUNNING = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [31:0]         arg_q [NumArgs];
   logic [NrCores-1:0]  evt_mask_q;
   logic [ArgW-1:0]     q_args [QDepth];
   logic [7:0]          q_id [QDepth];
   logic [1:0]          count_q, count_d;
   logic [7:0]          next_id_q;
   logic [7:0]          run_id_q;
   logic [7:0]          last_done_q;

   logic [5:0]          word_c;
   logic                wr_c;
   logic                trig_wr_c;
   logic                clr_wr_c;
   logic                full_c;
   logic                push_c;
   logic                pop_c;
   logic                done_run_c;
   logic [1:0]          wr_idx_c;
   logic [ArgW-1:0]     snapshot_c;
   logic [31:0]         rdata_c;
   logic                unused_c;

   // Only add_i[7:2] takes part in the decode
   assign unused_c = ^{ctrl.add_i[31:8], ctrl.add_i[1:0]};

   // Request decode
   assign word_c    = ctrl.add_i[7:2];
   assign wr_c      = ctrl.req_i & ctrl.wen_i;
   assign trig_wr_c = wr_c & (word_c == OffTrigger) & (|ctrl.be_i);
   assign clr_wr_c  = wr_c & (word_c == OffClear) & (|ctrl.be_i);

   // Queue occupancy as seen by TRIGGER; only registered state, so a pop in
   // the same cycle does not release a stalled trigger
`ifdef HWPE_JOB_CTRL_SHADOW_EN
   assign full_c = (count_q == 2'd2);
`else
   assign full_c = (count_q == 2'd1) | (state_q == RUNNING);
`endif

   assign ctrl.gnt_o = ctrl.req_i & ~(trig_wr_c & full_c);

   assign job_valid_o = (state_q == PENDING);
   assign job_args_o  = q_args[0];
   assign job_id_o    = q_id[0];

   // Argument snapshot taken by TRIGGER
   always_comb begin
      snapshot_c = '0;
      for (int i = 0; i < NumArgs; i++) begin
         snapshot_c[i*32 +: 32] = arg_q[i];
      end
   end

   // Next-state and queue control
   always_comb begin
      state_d    = state_q;
      push_c     = trig_wr_c & ~full_c;
      pop_c      = (state_q == PENDING) & job_ready_i;
      done_run_c = (state_q == RUNNING) & job_done_i;
      count_d    = count_q + 2'(push_c) - 2'(pop_c);
      wr_idx_c   = count_q - 2'(pop_c);

      unique case (state_q)
         IDLE:    if (push_c) state_d = PENDING;
         PENDING: if (pop_c) state_d = RUNNING;
         RUNNING: if (job_done_i) state_d = (count_d != 2'd0) ? PENDING : IDLE;
         default: state_d = IDLE;
      endcase

      // CLEAR overrides everything except the completion event of this cycle
      if (clr_wr_c) begin
         state_d = IDLE;
         count_d = 2'd0;
      end
   end

   // Register read mux
   always_comb begin
      rdata_c = '0;
      unique case (word_c)
         OffStatus:  rdata_c = {8'h00, next_id_q, last_done_q, 5'b0,
                                (count_q == 2'd0), full_c, (state_q == RUNNING)};
         OffEvtMask: rdata_c = 32'(evt_mask_q);
         default: begin
            for (int i = 0; i < NumArgs; i++) begin
               if (word_c == 6'(OffArgBase + 6'(i))) rdata_c = arg_q[i];
            end
         end
      endcase
   end

   // FSM state register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Staging registers with byte enables
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < NumArgs; i++) arg_q[i] <= '0;
         evt_mask_q <= '0;
      end else if (wr_c) begin
         for (int i = 0; i < NumArgs; i++) begin
            if (word_c == 6'(OffArgBase + 6'(i))) begin
               for (int b = 0; b < 4; b++) begin
                  if (ctrl.be_i[b]) arg_q[i][b*8 +: 8] <= ctrl.data_i[b*8 +: 8];
               end
            end
         end
         if (word_c == OffEvtMask) begin
            for (int b = 0; b < NrCores; b++) begin
               if (ctrl.be_i[b/8]) evt_mask_q[b] <= ctrl.data_i[b];
            end
         end
      end
   end

   // Job queue: entry 0 is the head, a pop shifts towards it
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_q <= 2'd0;
         for (int i = 0; i < QDepth; i++) begin
            q_args[i] <= '0;
            q_id[i]   <= '0;
         end
      end else begin
         count_q <= count_d;
         for (int i = 0; i < QDepth; i++) begin
            if (push_c && (wr_idx_c == 2'(i))) begin
               q_args[i] <= snapshot_c;
               q_id[i]   <= next_id_q;
            end else if (pop_c && (i + 1 < QDepth)) begin
               q_args[i] <= q_args[(i + 1 < QDepth) ? i + 1 : i];
               q_id[i]   <= q_id[(i + 1 < QDepth) ? i + 1 : i];
            end
         end
      end
   end

   // Job ids, completion events and control-port response
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         next_id_q      <= '0;
         run_id_q       <= '0;
         last_done_q    <= '0;
         evt_o          <= '0;
         ctrl.r_valid_o <= 1'b0;
         ctrl.r_data_o  <= '0;
      end else begin
         if (clr_wr_c)    next_id_q <= '0;
         else if (push_c) next_id_q <= next_id_q + 8'd1;
         if (pop_c)       run_id_q <= q_id[0];
         if (done_run_c)  last_done_q <= run_id_q;
         evt_o          <= done_run_c ? evt_mask_q : '0;
         ctrl.r_valid_o <= ctrl.gnt_o;
         ctrl.r_data_o  <= (ctrl.gnt_o & ~ctrl.wen_i) ? rdata_c : '0;
      end
   end

endmodule
